hangman_controller: RTL and testbench

- Control FSM for the Blind Hangman game: five-letter secret word, 7 tries.
- Sequences the game datapath: word load, guess capture, tries counter, win/lose flag registers.
- Tracks internally which of the 5 word positions are revealed.
- The datapath compares the latched guess against each word letter and returns a 5-bit per-position match vector.

---
 rtl/hangman_controller.sv | 89 ++++++++
 tb/tb_hangman_controller.sv | 122 ++++++++++++
 2 files changed

// File: rtl/hangman_controller.sv
// hangman_controller: control FSM for a five-letter, seven-try Blind Hangman game.
module hangman_controller #(
  parameter int MAX_TRIES = 7,
  parameter int WORD_LEN  = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                guess_valid,
  input  logic [WORD_LEN-1:0] input_char_eq_word,
  output logic                guessed_letters_is_done,
  output logic                s_tries,
  output logic                en_tries,
  output logic [2:0]          s_guessed_letters,
  output logic [2:0]          en_guessed_letters,
  output logic                en_word_index,
  output logic                en_input_char,
  output logic                s_win,
  output logic                en_win,
  output logic                s_lose,
  output logic                en_lose,
  output logic [2:0]          tries_left
);
  typedef enum logic [2:0] {IDLE, INIT, WAIT, CHECK, WIN, LOSE} state_t;
  state_t              r_state;
  logic [2:0]          r_tries;
  logic [2:0]          r_count;
  logic [WORD_LEN-1:0] r_mask;
  logic                r_first;
  logic [WORD_LEN-1:0] w_new;
  logic [2:0]          w_pop;
  logic [2:0]          w_count_next;
  logic                w_miss;
  assign w_new        = input_char_eq_word & ~r_mask;
  assign w_miss       = input_char_eq_word == '0;
  assign w_count_next = r_count + w_pop;
  always_comb begin
    w_pop = '0;
    for (int k = 0; k < WORD_LEN; k++) w_pop = w_pop + 3'(w_new[k]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_tries <= '0;
      r_count <= '0;
      r_mask  <= '0;
      r_first <= 1'b0;
    end else begin
      // the first cycle of WIN/LOSE is the one right after CHECK
      r_first <= r_state == CHECK;
      case (r_state)
        IDLE: if (start) r_state <= INIT;
        INIT: begin
          r_tries <= 3'(MAX_TRIES);
          r_count <= '0;
          r_mask  <= '0;
          r_state <= WAIT;
        end
        WAIT: r_state <= start ? INIT : guess_valid ? CHECK : WAIT;
        CHECK: begin
          if (w_miss) begin
            r_tries <= (r_tries != '0) ? r_tries - 3'd1 : r_tries;
            r_state <= (r_tries == 3'd1) ? LOSE : WAIT;
          end else begin
            r_mask  <= r_mask | input_char_eq_word;
            r_count <= w_count_next;
            r_state <= (w_count_next == 3'(WORD_LEN)) ? WIN : WAIT;
          end
        end
        WIN, LOSE: if (start) r_state <= INIT;
        default: r_state <= IDLE;
      endcase
    end
  end
  always_comb begin
    s_tries                 = r_state == INIT;
    en_tries                = (r_state == INIT) || (r_state == CHECK && w_miss);
    en_word_index           = r_state == INIT;
    en_input_char           = (r_state == WAIT) && guess_valid && !start;
    en_guessed_letters      = (r_state == CHECK) ? w_pop : 3'd0;
    s_win                   = r_state == WIN;
    en_win                  = (r_state == INIT) || (r_state == WIN && r_first);
    s_lose                  = r_state == LOSE;
    en_lose                 = (r_state == INIT) || (r_state == LOSE && r_first);
    s_guessed_letters       = r_count;
    guessed_letters_is_done = r_count == 3'(WORD_LEN);
    tries_left              = r_tries;
  end
endmodule

// File: tb/tb_hangman_controller.sv
// tb_hangman_controller: directed plus randomized checks against a game-rule reference model.
module tb_hangman_controller;
  logic       clk = 0;
  logic       reset, start, guess_valid;
  logic [4:0] input_char_eq_word;
  logic       guessed_letters_is_done, s_tries, en_tries, en_word_index, en_input_char;
  logic       s_win, en_win, s_lose, en_lose;
  logic [2:0] s_guessed_letters, en_guessed_letters, tries_left;
  int         n_pass = 0, n_total = 0;
  localparam int P_IDLE = 0, P_INIT = 1, P_WAIT = 2, P_CHECK = 3, P_WIN = 4, P_LOSE = 5;
  int         ph, tries, count, age;
  bit [4:0]   revealed;

  hangman_controller dut (
    .clk(clk), .reset(reset), .start(start), .guess_valid(guess_valid),
    .input_char_eq_word(input_char_eq_word),
    .guessed_letters_is_done(guessed_letters_is_done), .s_tries(s_tries), .en_tries(en_tries),
    .s_guessed_letters(s_guessed_letters), .en_guessed_letters(en_guessed_letters),
    .en_word_index(en_word_index), .en_input_char(en_input_char),
    .s_win(s_win), .en_win(en_win), .s_lose(s_lose), .en_lose(en_lose), .tries_left(tries_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic cyc(input bit r, input bit st, input bit gv, input bit [4:0] m);
    int gain, nph;
    reset = r; start = st; guess_valid = gv; input_char_eq_word = m;
    gain = $countones(m & ~revealed);
    @(negedge clk);
    check("s_tries", s_tries, ph == P_INIT);
    check("en_tries", en_tries, ph == P_INIT || (ph == P_CHECK && m == 0));
    check("en_word_index", en_word_index, ph == P_INIT);
    check("en_input_char", en_input_char, ph == P_WAIT && gv && !st);
    check("en_guessed", en_guessed_letters, ph == P_CHECK ? gain : 0);
    check("s_win", s_win, ph == P_WIN);
    check("en_win", en_win, ph == P_INIT || (ph == P_WIN && age == 0));
    check("s_lose", s_lose, ph == P_LOSE);
    check("en_lose", en_lose, ph == P_INIT || (ph == P_LOSE && age == 0));
    check("tries_left", tries_left, tries);
    check("s_guessed", s_guessed_letters, count);
    check("done", guessed_letters_is_done, count == 5);
    @(posedge clk);
    nph = ph;
    if (r) begin
      nph = P_IDLE; tries = 0; count = 0; revealed = 0;
    end else if (ph == P_INIT) begin
      nph = P_WAIT; tries = 7; count = 0; revealed = 0;
    end else if (ph == P_CHECK) begin
      if (m == 0) begin
        nph = (tries == 1) ? P_LOSE : P_WAIT;
        if (tries > 0) tries--;
      end else begin
        count += gain;
        revealed |= m;
        nph = (count == 5) ? P_WIN : P_WAIT;
      end
    end else if (st) nph = P_INIT;
    else if (ph == P_WAIT && gv) nph = P_CHECK;
    age = (nph == ph) ? age + 1 : 0;
    ph = nph;
    #1;
  endtask

  task automatic guess(input bit [4:0] m);
    cyc(0, 0, 1, m);
    cyc(0, 0, 0, m);
  endtask

  initial begin
    ph = P_IDLE; tries = 0; count = 0; revealed = 0; age = 0;
    reset = 1; start = 0; guess_valid = 0; input_char_eq_word = 0;
    repeat (2) @(posedge clk);
    #1;
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (7) guess(5'b00000);
    repeat (3) cyc(0, 0, 1, 0);
    check("lose_reached", s_lose, 1);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) guess(5'b00001 << i);
    repeat (2) cyc(0, 0, 1, 0);
    check("win_reached", s_win, 1);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    guess(5'b10001);
    guess(5'b10001);
    check("dup_count", s_guessed_letters, 2);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    repeat (6) guess(5'b00000);
    guess(5'b00111);
    guess(5'b11000);
    check("last_try_win", s_win, 1);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    guess(5'b00100);
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 5'b01000);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit [4:0] m;
      case ($urandom % 4)
        0: m = 0;
        1: m = 5'b00001 << ($urandom % 5);
        2: m = 5'($urandom);
        default: m = 0;
      endcase
      cyc($urandom % 300 == 0, $urandom % 30 == 0, $urandom % 2 == 0, m);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
